// File: rtl/vc_link_tx_if.sv
// Link-side bundle for vc_link_tx: per-VC source handshake, registered flit stream,
// per-VC downstream backpressure and status. master = transmitter, slave = environment.
interface vc_link_tx_if #(
    parameter int unsigned N_VC   = 4,
    parameter int unsigned VC_W   = 2,
    parameter int unsigned FLIT_W = 34
);
    logic [N_VC-1:0]        vc_valid_i;
    logic [N_VC*FLIT_W-1:0] vc_fdata_i;
    logic [N_VC-1:0]        vc_ready_o;
    logic [FLIT_W-1:0]      fdata_o;
    logic [VC_W-1:0]        vc_id_o;
    logic                   valid_o;
    logic [N_VC-1:0]        ready_i;
    logic                   locked_o;
    logic                   err_o;

    modport master (
        input  vc_valid_i, vc_fdata_i, ready_i,
        output vc_ready_o, fdata_o, vc_id_o, valid_o, locked_o, err_o
    );

    modport slave (
        output vc_valid_i, vc_fdata_i, ready_i,
        input  vc_ready_o, fdata_o, vc_id_o, valid_o, locked_o, err_o
    );
endinterface

// File: rtl/vc_link_tx.sv
// Inter-router link transmitter: packet-granular round-robin over N_VC sources,
// wormhole-locked from head to tail, single registered output stage with per-VC backpressure.
module vc_link_tx #(
    parameter int unsigned N_VC   = 4,
    parameter int unsigned VC_W   = 2,
    parameter int unsigned FLIT_W = 34
) (
    input  logic          clk,
    input  logic          arst,
    vc_link_tx_if.master  lnk
);
    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    localparam logic [1:0] TyHead = 2'b00;
    localparam logic [1:0] TyTail = 2'b11;

    state_e              state_q;
    logic [VC_W-1:0]     rr_q, lock_vc_q, vc_id_q;
    logic                valid_q, err_q;
    logic [FLIT_W-1:0]   fdata_q;

    logic [FLIT_W-1:0]   flit [N_VC];
    logic [N_VC-1:0]     is_head;
    logic                out_free;
    logic                gnt_found, bad_found, accept, load;
    logic [VC_W-1:0]     gnt_vc, bad_vc, cand, sel_vc;
    logic [N_VC-1:0]     vc_ready;
    logic [1:0]          sel_type;

    for (genvar v = 0; v < N_VC; v++) begin : g_split
        assign flit[v]    = lnk.vc_fdata_i[v*FLIT_W +: FLIT_W];
        assign is_head[v] = (flit[v][FLIT_W-1 -: 2] == TyHead);
    end

    assign out_free = !valid_q || lnk.ready_i[vc_id_q];

    always_comb begin
        gnt_found = 1'b0;
        gnt_vc    = '0;
        cand      = '0;
        for (int i = 1; i <= N_VC; i++) begin
            cand = rr_q + VC_W'(i);
            if (!gnt_found && lnk.vc_valid_i[cand] && is_head[cand]) begin
                gnt_found = 1'b1;
                gnt_vc    = cand;
            end
        end
        // Downward scan so the lowest-index offender wins the discard slot.
        bad_found = 1'b0;
        bad_vc    = '0;
        for (int i = N_VC - 1; i >= 0; i--) begin
            if (lnk.vc_valid_i[i] && !is_head[i]) begin
                bad_found = 1'b1;
                bad_vc    = VC_W'(i);
            end
        end

        vc_ready = '0;
        if (!arst && out_free) begin
            unique case (state_q)
                StIdle: begin
                    if (gnt_found)      vc_ready[gnt_vc] = 1'b1;
                    else if (bad_found) vc_ready[bad_vc] = 1'b1;
                end
                StLocked: vc_ready[lock_vc_q] = 1'b1;
                default: ;
            endcase
        end

        if (state_q == StLocked) sel_vc = lock_vc_q;
        else if (gnt_found)      sel_vc = gnt_vc;
        else                     sel_vc = bad_vc;

        sel_type = flit[sel_vc][FLIT_W-1 -: 2];
        accept   = |(vc_ready & lnk.vc_valid_i);
        // Discarded non-heads in IDLE are consumed without touching the output stage.
        load     = accept && ((state_q == StLocked) || gnt_found);
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state_q   <= StIdle;
            rr_q      <= VC_W'(N_VC - 1);
            lock_vc_q <= '0;
            vc_id_q   <= '0;
            valid_q   <= 1'b0;
            fdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (load) begin
                valid_q <= 1'b1;
                fdata_q <= flit[sel_vc];
                vc_id_q <= sel_vc;
            end else if (valid_q && lnk.ready_i[vc_id_q]) begin
                valid_q <= 1'b0;
            end

            if (accept) begin
                unique case (state_q)
                    StIdle: begin
                        if (gnt_found) begin
                            lock_vc_q <= gnt_vc;
                            state_q   <= StLocked;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    StLocked: begin
                        if (sel_type == TyTail) begin
                            state_q <= StIdle;
                            rr_q    <= lock_vc_q;
                        end else if (sel_type == TyHead) begin
                            err_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign lnk.vc_ready_o = vc_ready;
    assign lnk.fdata_o    = fdata_q;
    assign lnk.vc_id_o    = vc_id_q;
    assign lnk.valid_o    = valid_q;
    assign lnk.locked_o   = (state_q == StLocked);
    assign lnk.err_o      = err_q;
endmodule

// File: tb/tb_vc_link_tx.sv
// Directed bench for vc_link_tx: per-VC source queues drive the DUT, and every link
// transfer is compared against a hand-written expected flit list.
module tb_vc_link_tx;
    logic clk = 1'b0;
    logic arst;
    always #5 clk = ~clk;

    vc_link_tx_if lnk ();

    vc_link_tx dut (
        .clk  (clk),
        .arst (arst),
        .lnk  (lnk)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [33:0] srcq [4][$];
    logic [35:0] expq [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic src_busy();
        logic b = 1'b0;
        for (int v = 0; v < 4; v++) if (srcq[v].size() > 0) b = 1'b1;
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle-by-cycle driver: present queue fronts, pop on accept, check transfers in order.
    task automatic run(input string tag, input int stall_vc, input int stall_start,
                       input int stall_len, input int min_c, input int exp_cycles,
                       input int exp_errs);
        int          c = 0;
        int          errs = 0;
        logic        hold = 1'b0;
        logic [35:0] prev = '0;
        logic [35:0] e;
        logic [3:0]  acc;
        while ((c < min_c || expq.size() > 0 || src_busy()) && c < 200) begin
            lnk.ready_i = 4'hF;
            if (c >= stall_start && c < stall_start + stall_len) lnk.ready_i[stall_vc] = 1'b0;
            for (int v = 0; v < 4; v++) begin
                lnk.vc_valid_i[v] = (srcq[v].size() > 0);
                lnk.vc_fdata_i[v*34 +: 34] = (srcq[v].size() > 0) ? srcq[v][0] : 34'h0;
            end
            #1;
            acc = lnk.vc_ready_o & lnk.vc_valid_i;
            check({tag, " onehot"}, 64'($countones(lnk.vc_ready_o) <= 1), 64'd1);
            if (hold) check({tag, " hold"}, {lnk.vc_id_o, lnk.fdata_o}, prev);
            if (lnk.valid_o && !lnk.ready_i[lnk.vc_id_o]) begin
                check({tag, " stall rdy"}, lnk.vc_ready_o, 4'h0);
                hold = 1'b1;
                prev = {lnk.vc_id_o, lnk.fdata_o};
            end else begin
                hold = 1'b0;
            end
            if (lnk.valid_o && lnk.ready_i[lnk.vc_id_o]) begin
                if (expq.size() == 0) begin
                    check({tag, " extra flit"}, lnk.valid_o, 1'b0);
                end else begin
                    e = expq.pop_front();
                    check({tag, " flit"}, {lnk.vc_id_o, lnk.fdata_o}, e);
                end
            end
            if (lnk.err_o) errs++;
            tick();
            for (int v = 0; v < 4; v++) if (acc[v]) void'(srcq[v].pop_front());
            c++;
        end
        lnk.vc_valid_i = '0;
        lnk.ready_i    = 4'hF;
        check({tag, " cycles"}, c, exp_cycles);
        check({tag, " errs"}, errs, exp_errs);
    endtask

    initial begin
        arst           = 1'b1;
        lnk.ready_i    = 4'hF;
        lnk.vc_valid_i = 4'hF;
        for (int v = 0; v < 4; v++) lnk.vc_fdata_i[v*34 +: 34] = 34'h0_0C00_0010 + 34'(v);

        // Reset with every source valid, then first grant must go to VC0.
        tick();
        tick();
        check("rst valid", lnk.valid_o, 1'b0);
        check("rst fdata", lnk.fdata_o, 34'h0);
        check("rst vc_ready", lnk.vc_ready_o, 4'h0);
        check("rst locked", lnk.locked_o, 1'b0);
        check("rst err", lnk.err_o, 1'b0);
        arst = 1'b0;
        #1;
        check("first gnt", lnk.vc_ready_o, 4'b0001);
        tick();
        check("first valid", lnk.valid_o, 1'b1);
        check("first id", lnk.vc_id_o, 2'd0);
        check("first data", lnk.fdata_o, 34'h0_0C00_0010);
        check("first locked", lnk.locked_o, 1'b1);
        lnk.vc_valid_i = 4'b0001;
        lnk.vc_fdata_i[0 +: 34] = 34'h3_0000_0011;
        #1;
        check("tail rdy", lnk.vc_ready_o, 4'b0001);
        tick();
        check("tail data", lnk.fdata_o, 34'h3_0000_0011);
        check("tail unlock", lnk.locked_o, 1'b0);
        lnk.vc_valid_i = 4'b0000;
        tick();
        check("drain valid", lnk.valid_o, 1'b0);

        // Single packet on VC2.
        srcq[2] = '{34'h0_0C00_0001, 34'h1_0000_0002, 34'h3_0000_0003};
        expq    = '{{2'd2, 34'h0_0C00_0001}, {2'd2, 34'h1_0000_0002}, {2'd2, 34'h3_0000_0003}};
        run("vc2 pkt", 0, 0, 0, 0, 4, 0);
        check("vc2 idle", lnk.valid_o, 1'b0);

        // VC0 and VC1 contend; second VC0 packet must wait behind VC1.
        srcq[0] = '{34'h0_0C00_00A0, 34'h1_0000_00A1, 34'h3_0000_00A2,
                    34'h0_0C00_00C0, 34'h2_0000_00C1, 34'h3_0000_00C2};
        srcq[1] = '{34'h0_0C00_00B0, 34'h1_0000_00B1, 34'h3_0000_00B2};
        expq    = '{{2'd0, 34'h0_0C00_00A0}, {2'd0, 34'h1_0000_00A1}, {2'd0, 34'h3_0000_00A2},
                    {2'd1, 34'h0_0C00_00B0}, {2'd1, 34'h1_0000_00B1}, {2'd1, 34'h3_0000_00B2},
                    {2'd0, 34'h0_0C00_00C0}, {2'd0, 34'h2_0000_00C1}, {2'd0, 34'h3_0000_00C2}};
        run("contend", 0, 0, 0, 0, 10, 0);

        // Three-cycle backpressure on VC1 mid-packet.
        srcq[1] = '{34'h0_0C00_0031, 34'h1_0000_0032, 34'h3_0000_0033};
        expq    = '{{2'd1, 34'h0_0C00_0031}, {2'd1, 34'h1_0000_0032}, {2'd1, 34'h3_0000_0033}};
        run("bkpr", 1, 2, 3, 0, 7, 0);

        // Stray body on idle VC3 is discarded with an error pulse.
        srcq[3] = '{34'h1_0000_0005};
        run("stray body", 0, 0, 0, 3, 3, 1);

        // Head while locked is forwarded and flagged.
        srcq[2] = '{34'h0_0C00_0021, 34'h0_0C00_0022, 34'h3_0000_0023};
        expq    = '{{2'd2, 34'h0_0C00_0021}, {2'd2, 34'h0_0C00_0022}, {2'd2, 34'h3_0000_0023}};
        run("head in lock", 0, 0, 0, 0, 4, 1);

        // Reset mid-packet abandons VC0; VC1 head wins immediately afterwards.
        lnk.vc_valid_i = 4'b0001;
        lnk.vc_fdata_i[0 +: 34] = 34'h0_0C00_00D0;
        tick();
        check("mid locked", lnk.locked_o, 1'b1);
        check("mid valid", lnk.valid_o, 1'b1);
        arst = 1'b1;
        lnk.vc_valid_i = 4'b0000;
        tick();
        check("mid rst valid", lnk.valid_o, 1'b0);
        check("mid rst locked", lnk.locked_o, 1'b0);
        arst = 1'b0;
        lnk.vc_valid_i = 4'b0011;
        lnk.vc_fdata_i[0 +: 34]  = 34'h1_0000_00D1;
        lnk.vc_fdata_i[34 +: 34] = 34'h0_0C00_00E0;
        #1;
        check("post rst gnt", lnk.vc_ready_o, 4'b0010);
        tick();
        check("post rst id", lnk.vc_id_o, 2'd1);
        check("post rst data", lnk.fdata_o, 34'h0_0C00_00E0);
        check("post rst err", lnk.err_o, 1'b0);
        lnk.vc_valid_i = 4'b0000;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/vc_link_tx.md
Name: vc_link_tx

Overview:
Transmit end of the inter-router link that feeds the per-VC input buffers of the downstream router. Collects flits from N_VC upstream virtual-channel sources and arbitrates among them round-robin at packet granularity (wormhole: locked from head to tail). Drives one registered flit stream tagged with vc_id_o. Obeys per-VC backpressure returned by the downstream VC buffers.

Parameters:
N_VC, 4, number of virtual channels (power of 2, >=2)
VC_W, 2, width of VC id (log2 N_VC)
FLIT_W, 34, flit width; bits [FLIT_W-1:FLIT_W-2] are flit type

Ports:
clk  in  1  clock, all logic on rising edge
arst  in  1  reset, synchronous, active-high
vc_valid_i  in  N_VC  per-VC source flit valid
vc_fdata_i  in  N_VC*FLIT_W  per-VC source flit, VC v at [v*FLIT_W +: FLIT_W]
vc_ready_o  out  N_VC  per-VC source accept (combinational)
fdata_o  out  FLIT_W  link flit (registered)
vc_id_o  out  VC_W  VC tag of fdata_o (registered)
valid_o  out  1  link flit valid (registered)
ready_i  in  N_VC  per-VC ready from downstream VC buffers
locked_o  out  1  1 while a packet holds the link (state LOCKED)
err_o  out  1  one-cycle pulse on protocol violation (registered)

Behaviour:
- Flit type = fdata[33:32]: 00 head, 01/10 body, 11 tail. A packet is head, zero or more bodies, then tail. Single-flit packets are not supported.
- Reset (arst=1 at clk edge): valid_o=0, fdata_o=0, vc_id_o=0, err_o=0, state IDLE, locked_o=0, rr pointer set so VC0 has top priority. Any flit held in the output register is dropped. Reset mid-packet abandons the packet.
- out_free = !valid_o | ready_i[vc_id_o]. Link transfer occurs when valid_o & ready_i[vc_id_o].
- Output hold: while valid_o & !ready_i[vc_id_o], fdata_o and vc_id_o stay stable.
- State IDLE:
  - grant = first v, scanning round-robin from rr+1, with vc_valid_i[v] and head type.
  - If out_free and a grant exists: vc_ready_o[grant]=1, the head is loaded into the output register next edge (vc_id_o=grant), lock_vc=grant, state goes to LOCKED.
  - Non-head flit at the front of an unlocked VC: that VC is not eligible. If out_free and no head grant exists, the lowest-index such VC gets vc_ready_o=1. Its flit is discarded and err_o pulses the next cycle.
- State LOCKED:
  - Only lock_vc is served. vc_ready_o[lock_vc] = out_free; all other vc_ready_o bits are 0.
  - Accepted flits load the output register, one per cycle.
  - Accepted tail: state goes to IDLE and rr=lock_vc at the next edge. A new head (any VC) may be accepted the very next cycle, so there is no bubble.
  - Accepted head while LOCKED: forwarded unchanged, err_o pulses, lock is kept.
- Latency: source accept to valid_o is 1 cycle. Sustained throughput is 1 flit/cycle when ready_i[vc_id_o] is held high.
- At most one vc_ready_o bit is high in any cycle. vc_ready_o never depends on vc_valid_i of the same VC in LOCKED.
- The output register is loaded only on source accept. On link transfer with no accept, valid_o drops to 0.
- locked_o = (state==LOCKED).

Test Plan:
- Reset: hold arst for 2 cycles with all vc_valid_i=1 -> valid_o=0, fdata_o=0, vc_ready_o=0 during reset. First grant after reset goes to VC0.
- Single packet on VC2 (head 0x0_0C00_0001, body 0x1_0000_0002, tail 0x3_0000_0003), ready_i=4'hF:
  - -> three consecutive valid_o cycles, vc_id_o=2, data in order, locked_o 1 for cycles 2-3, then 0.
- Contention: VC0 and VC1 each present a 3-flit packet simultaneously -> VC0 packet fully sent first, no interleaving. VC1 head follows VC0 tail with no idle cycle. A second VC0 packet waits behind VC1 (round-robin).
- Backpressure: ready_i[1]=0 for 3 cycles mid-packet on VC1 -> fdata_o and vc_id_o stable, vc_ready_o[1]=0 while stalled. No flit lost or duplicated after ready_i[1] returns to 1.
- Protocol errors:
  - body 0x1_0000_0005 on VC3 while IDLE, no other valid -> flit consumed, valid_o stays 0, err_o pulses once.
  - head arriving while LOCKED -> forwarded, err_o pulses once.
- Reset mid-packet: arst asserted after the head of a VC0 packet -> valid_o=0, locked_o=0. After reset, a VC1 head is granted immediately.
